// File: rtl/des_dec_key_sched.sv
// DES key schedule: emits the 16 PC-2 subkeys K16..K1 (decryption order) over a valid/ready handshake.
// Optional macro DES_DEC_KEY_SCHED_ENC_MODE_EN adds enc_mode, selecting K1..K16 order at key acceptance.
module des_dec_key_sched (
  input  logic        clk,
  input  logic        rst_n,
`ifdef DES_DEC_KEY_SCHED_ENC_MODE_EN
  input  logic        enc_mode,
`endif
  input  logic        key_valid,
  input  logic [63:0] key,
  output logic        key_ready,
  output logic        subkey_valid,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  input  logic        subkey_ready,
  output logic        done
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Tables use FIPS 46-3 numbering: entry n selects input bit n, bit 1 being the MSB.
  localparam logic [6:0] PC1_TAB [0:55] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [6:0] PC2_TAB [0:47] = '{
    7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,  7'd3,  7'd28, 7'd15, 7'd6,  7'd21, 7'd10,
    7'd23, 7'd19, 7'd12, 7'd4,  7'd26, 7'd8,  7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
    7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55, 7'd30, 7'd40, 7'd51, 7'd45, 7'd33, 7'd48,
    7'd44, 7'd49, 7'd39, 7'd56, 7'd34, 7'd53, 7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] v;
    v = 56'd0;
    for (int i = 0; i < 56; i++) v[55-i] = k[64 - int'(PC1_TAB[i])];
    return v;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] v;
    v = 48'd0;
    for (int i = 0; i < 48; i++) v[47-i] = cd[56 - int'(PC2_TAB[i])];
    return v;
  endfunction

  function automatic logic [27:0] rot_r(input logic [27:0] x, input logic one);
    if (one) rot_r = {x[0], x[27:1]};
    else     rot_r = {x[1:0], x[27:2]};
  endfunction

  function automatic logic [27:0] rot_l(input logic [27:0] x, input logic one);
    if (one) rot_l = {x[26:0], x[27]};
    else     rot_l = {x[25:0], x[27:26]};
  endfunction

  state_t      r_state, w_state_nxt;
  logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
  logic [3:0]  r_idx, w_idx_nxt, w_idx_step;
  logic        r_enc, w_enc_nxt, r_done, w_done_nxt;
  logic        w_enc_sel, w_last, w_one;
  logic [55:0] w_cd_load;

`ifdef DES_DEC_KEY_SCHED_ENC_MODE_EN
  assign w_enc_sel = enc_mode;
`else
  assign w_enc_sel = 1'b0;
`endif

  // Next-state and datapath update: load PC-1 on accept, rotate C/D on each non-final transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_idx_nxt   = r_idx;
    w_enc_nxt   = r_enc;
    w_done_nxt  = 1'b0;
    w_cd_load   = pc1(key);
    w_last      = r_enc ? (r_idx == 4'd15) : (r_idx == 4'd0);
    w_idx_step  = r_enc ? (r_idx + 4'd1) : (r_idx - 4'd1);
    // Single-bit steps undo/apply the shifts of rounds 1, 2, 9 and 16.
    w_one       = r_enc ? ((w_idx_step == 4'd1) || (w_idx_step == 4'd8) || (w_idx_step == 4'd15))
                        : ((w_idx_step == 4'd14) || (w_idx_step == 4'd7) || (w_idx_step == 4'd0));
    case (r_state)
      ST_IDLE: begin
        if (key_valid) begin
          w_state_nxt = ST_RUN;
          w_enc_nxt   = w_enc_sel;
          if (w_enc_sel) begin
            w_c_nxt   = rot_l(w_cd_load[55:28], 1'b1);
            w_d_nxt   = rot_l(w_cd_load[27:0], 1'b1);
            w_idx_nxt = 4'd0;
          end else begin
            w_c_nxt   = w_cd_load[55:28];
            w_d_nxt   = w_cd_load[27:0];
            w_idx_nxt = 4'd15;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (subkey_ready) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else if (r_enc) begin
            w_c_nxt   = rot_l(r_c, w_one);
            w_d_nxt   = rot_l(r_d, w_one);
            w_idx_nxt = w_idx_step;
          end else begin
            w_c_nxt   = rot_r(r_c, w_one);
            w_d_nxt   = rot_r(r_d, w_one);
            w_idx_nxt = w_idx_step;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_c     <= 28'd0;
      r_d     <= 28'd0;
      r_idx   <= 4'd0;
      r_enc   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_idx   <= w_idx_nxt;
      r_enc   <= w_enc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign key_ready    = (r_state == ST_IDLE);
  assign subkey_valid = (r_state == ST_RUN);
  assign round_idx    = r_idx;
  assign done         = r_done;
  assign subkey       = pc2({r_c, r_d});

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Self-checking bench for des_dec_key_sched: table of key runs plus hand-written reset sequences.
module tb_des_dec_key_sched;

  logic        clk = 1'b0;
  logic        rst_n, key_valid, subkey_ready;
  logic [63:0] key;
  logic        key_ready, subkey_valid, done;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
`ifdef DES_DEC_KEY_SCHED_ENC_MODE_EN
  logic        enc_mode;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  des_dec_key_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef DES_DEC_KEY_SCHED_ENC_MODE_EN
    .enc_mode     (enc_mode),
`endif
    .key_valid    (key_valid),
    .key          (key),
    .key_ready    (key_ready),
    .subkey_valid (subkey_valid),
    .subkey       (subkey),
    .round_idx    (round_idx),
    .subkey_ready (subkey_ready),
    .done         (done)
  );

  typedef struct {
    logic [63:0] k;
    int          bp_mode;  // 0: always ready, 1: ready pattern 1,0,0, 2: random
    bit          busy;
    bit          enc;
  } run_vec_t;

  logic [47:0] ks [0:15];  // ks[i] = K(i+1) for key 0x133457799BBCDFF1
  run_vec_t    runs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_seq(input run_vec_t v);
    int          n, cyc, eidx;
    logic        rdy, stalled;
    logic [47:0] prev_sk;
    logic [3:0]  prev_idx;
    check("accept_ready", {63'd0, key_ready}, 64'd1);
    key       = v.k;
    key_valid = 1'b1;
`ifdef DES_DEC_KEY_SCHED_ENC_MODE_EN
    enc_mode  = v.enc;
`endif
    @(posedge clk); #1;
    key_valid = 1'b0;
    n = 0; cyc = 0; stalled = 1'b0; prev_sk = 48'd0; prev_idx = 4'd0;
    while (n < 16 && cyc < 300) begin
      check("run_valid", {63'd0, subkey_valid}, 64'd1);
      check("run_key_ready", {63'd0, key_ready}, 64'd0);
      check("run_no_done", {63'd0, done}, 64'd0);
      if (stalled) begin
        check("hold_subkey", {16'd0, subkey}, {16'd0, prev_sk});
        check("hold_idx", {60'd0, round_idx}, {60'd0, prev_idx});
      end
      case (v.bp_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      subkey_ready = rdy;
      if (rdy) begin
        eidx = v.enc ? n : 15 - n;
        check("round_idx", {60'd0, round_idx}, 64'(eidx));
        check("subkey", {16'd0, subkey}, {16'd0, ks[eidx]});
        n++;
      end
      stalled  = !rdy;
      prev_sk  = subkey;
      prev_idx = round_idx;
      if (v.busy) begin
        key       = 64'hFFFF_FFFF_FFFF_FFFF;
        key_valid = (n >= 4 && n < 9);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (n < 16) check("transfer_timeout", 64'(n), 64'd16);
    key_valid    = 1'b0;
    subkey_ready = 1'b0;
    check("done_pulse", {63'd0, done}, 64'd1);
    check("end_valid", {63'd0, subkey_valid}, 64'd0);
    check("end_key_ready", {63'd0, key_ready}, 64'd1);
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int cyc;
    ks[0]  = 48'h1B02EFFC7072; ks[1]  = 48'h79AED9DBC9E5; ks[2]  = 48'h55FC8A42CF99;
    ks[3]  = 48'h72ADD6DB351D; ks[4]  = 48'h7CEC07EB53A8; ks[5]  = 48'h63A53E507B2F;
    ks[6]  = 48'hEC84B7F618BC; ks[7]  = 48'hF78A3AC13BFB; ks[8]  = 48'hE0DBEBEDE781;
    ks[9]  = 48'hB1F347BA464F; ks[10] = 48'h215FD3DED386; ks[11] = 48'h7571F59467E9;
    ks[12] = 48'h97C5D1FABA41; ks[13] = 48'h5F43B7F2E73A; ks[14] = 48'hBF918D3D3F0A;
    ks[15] = 48'hCB3D8B0E17F5;
    runs.push_back('{64'h133457799BBCDFF1, 0, 1'b0, 1'b0});
    runs.push_back('{64'h133457799BBCDFF1, 1, 1'b0, 1'b0});
    runs.push_back('{64'h133457799BBCDFF1, 0, 1'b1, 1'b0});
    runs.push_back('{64'h123556789ABDDEF0, 2, 1'b0, 1'b0});
`ifdef DES_DEC_KEY_SCHED_ENC_MODE_EN
    runs.push_back('{64'h133457799BBCDFF1, 1, 1'b0, 1'b1});
    runs.push_back('{64'h133457799BBCDFF1, 0, 1'b0, 1'b0});
    enc_mode = 1'b0;
`endif

    rst_n = 1'b0; key_valid = 1'b0; subkey_ready = 1'b0; key = 64'd0;
    #3;
    check("rst_key_ready", {63'd0, key_ready}, 64'd1);
    check("rst_valid", {63'd0, subkey_valid}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_idx", {60'd0, round_idx}, 64'd0);
    check("rst_subkey", {16'd0, subkey}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (runs[i]) run_seq(runs[i]);

    // Reset abort in the middle of a sequence.
    key = 64'h133457799BBCDFF1; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; subkey_ready = 1'b1;
    cyc = 0;
    while (round_idx != 4'd8 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach_8", {60'd0, round_idx}, 64'd8);
    check("abort_subkey_k9", {16'd0, subkey}, {16'd0, ks[8]});
    #2 rst_n = 1'b0;
    #1;
    check("abort_key_ready", {63'd0, key_ready}, 64'd1);
    check("abort_valid", {63'd0, subkey_valid}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_idx", {60'd0, round_idx}, 64'd0);
    check("abort_subkey", {16'd0, subkey}, 64'd0);
    subkey_ready = 1'b0;
    @(posedge clk); #1;
    check("abort_no_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_done_after", {63'd0, done}, 64'd0);
    run_seq(runs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
